// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// -----------------------------------------------------------------------------
// Shares one SDRAM controller port among NUM_REQ masters that all use the
// controller's read/write/address/finished handshake. One transaction is in
// flight at a time: the winner's op, address and write data are latched at
// grant and held until the controller reports completion. Completion goes
// back only to the granted master, as a one-cycle finished pulse plus read
// data.
//
// Configuration macro:
//   SDRAM_ARB_RR_EN  defined   -> round-robin arbitration, search starts at
//                                 (last granted + 1) mod NUM_REQ
//                    undefined -> fixed priority, lowest index wins
//
// Ports:
//   i_clk            clock, all logic on rising edge
//   i_rst            synchronous reset, active low
//   req_read[i]      read request from master i
//   req_write[i]     write request from master i (wins over read)
//   req_addr[i]      word address from master i
//   req_writedata[i] write data from master i
//   req_readdata[i]  last read data returned to master i
//   req_finished[i]  one-cycle completion pulse to master i
//   sdram_read       read command to controller
//   sdram_write      write command to controller
//   sdram_addr       address to controller
//   sdram_writedata  write data to controller
//   sdram_readdata   read data from controller
//   sdram_finished   controller completion, valid while the command is held
//   arb_busy         high while a transaction is in BUSY or DONE
//   arb_grant        index of current / last granted master
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       req_read      [NUM_REQ-1:0],
    input  logic                       req_write     [NUM_REQ-1:0],
    input  logic [ADDR_W-1:0]          req_addr      [NUM_REQ-1:0],
    input  logic [DATA_W-1:0]          req_writedata [NUM_REQ-1:0],
    output logic [DATA_W-1:0]          req_readdata  [NUM_REQ-1:0],
    output logic                       req_finished  [NUM_REQ-1:0],
    output logic                       sdram_read,
    output logic                       sdram_write,
    output logic [ADDR_W-1:0]          sdram_addr,
    output logic [DATA_W-1:0]          sdram_writedata,
    input  logic [DATA_W-1:0]          sdram_readdata,
    input  logic                       sdram_finished,
    output logic                       arb_busy,
    output logic [$clog2(NUM_REQ)-1:0] arb_grant
);

    localparam int GRANT_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_is_write;   // latched op of the transaction in flight
    logic [NUM_REQ-1:0]   w_req;
    logic                 w_any;
    logic [GRANT_W-1:0]   w_winner;

`ifdef SDRAM_ARB_RR_EN
    logic [GRANT_W-1:0]   r_rr_ptr;     // last granted master

    function automatic logic [GRANT_W-1:0] wrap_idx(input int base, input int off);
        return GRANT_W'((base + off) % NUM_REQ);
    endfunction
`endif

    // Winner selection. Only consulted in IDLE; BUSY/DONE ignore requests.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_req    = '0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_req[k] = req_read[k] | req_write[k];
        end
`ifdef SDRAM_ARB_RR_EN
        // First requester found scanning upward from the one after r_rr_ptr.
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && w_req[wrap_idx(int'(r_rr_ptr), k)]) begin
                w_any    = 1'b1;
                w_winner = wrap_idx(int'(r_rr_ptr), k);
            end
        end
`else
        // Scan from the top so the lowest requesting index is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_any    = 1'b1;
                w_winner = GRANT_W'(k);
            end
        end
`endif
    end

    // NOTE: all state below is assigned with non-blocking (<=) so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state         <= ST_IDLE;
            r_is_write      <= 1'b0;
            sdram_read      <= 1'b0;
            sdram_write     <= 1'b0;
            sdram_addr      <= '0;
            sdram_writedata <= '0;
            arb_busy        <= 1'b0;
            arb_grant       <= '0;
            // NOTE: the read-data return registers are a small register
            // file, not RAM, so they take a reset like any other flop and
            // masters see defined data before their first read completes.
            for (int i = 0; i < NUM_REQ; i++) begin
                req_readdata[i] <= '0;
                req_finished[i] <= 1'b0;
            end
`ifdef SDRAM_ARB_RR_EN
            r_rr_ptr        <= GRANT_W'(NUM_REQ - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        arb_grant       <= w_winner;
                        r_is_write      <= req_write[w_winner];
                        sdram_write     <= req_write[w_winner];
                        sdram_read      <= ~req_write[w_winner];
                        sdram_addr      <= req_addr[w_winner];
                        sdram_writedata <= req_writedata[w_winner];
                        arb_busy        <= 1'b1;
                        r_state         <= ST_BUSY;
`ifdef SDRAM_ARB_RR_EN
                        r_rr_ptr        <= w_winner;
`endif
                    end
                end

                ST_BUSY: begin
                    // Command and latched address/data are held until the
                    // controller completes; master inputs are not looked at.
                    if (sdram_finished) begin
                        sdram_read  <= 1'b0;
                        sdram_write <= 1'b0;
                        if (!r_is_write) begin
                            req_readdata[arb_grant] <= sdram_readdata;
                        end
                        req_finished[arb_grant] <= 1'b1;
                        r_state                 <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_finished[i] <= 1'b0;
                    end
                    arb_busy <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter. A behavioural controller answers each command
// after a programmable latency; a scoreboard queue holds the expected
// (master, readdata) of every completion, and a monitor pops it on each
// finished pulse.
module tb_sdram_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int GW      = $clog2(NUM_REQ);

    logic                clk;
    logic                i_rst;
    logic                req_read      [NUM_REQ-1:0];
    logic                req_write     [NUM_REQ-1:0];
    logic [ADDR_W-1:0]   req_addr      [NUM_REQ-1:0];
    logic [DATA_W-1:0]   req_writedata [NUM_REQ-1:0];
    logic [DATA_W-1:0]   req_readdata  [NUM_REQ-1:0];
    logic                req_finished  [NUM_REQ-1:0];
    logic                sdram_read;
    logic                sdram_write;
    logic [ADDR_W-1:0]   sdram_addr;
    logic [DATA_W-1:0]   sdram_writedata;
    logic [DATA_W-1:0]   sdram_readdata;
    logic                sdram_finished;
    logic                arb_busy;
    logic [GW-1:0]       arb_grant;

    typedef struct {
        int                master;
        logic [DATA_W-1:0] data;
    } sb_t;

    sb_t               sb[$];
    sb_t               mon_e;
    logic [DATA_W-1:0] model_rd [NUM_REQ];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_done   = 0;

    // Controller model knobs
    int                ctl_lat   = 4;
    int                ctl_cnt   = 0;
    bit                ctl_mode  = 1'b0;   // 0: return ctl_rdata, 1: address-derived data
    logic [DATA_W-1:0] ctl_rdata = '0;

    sdram_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_writedata  (req_writedata),
        .req_readdata   (req_readdata),
        .req_finished   (req_finished),
        .sdram_read     (sdram_read),
        .sdram_write    (sdram_write),
        .sdram_addr     (sdram_addr),
        .sdram_writedata(sdram_writedata),
        .sdram_readdata (sdram_readdata),
        .sdram_finished (sdram_finished),
        .arb_busy       (arb_busy),
        .arb_grant      (arb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] addr_data(input logic [ADDR_W-1:0] a);
        return 32'hA5A5_0000 ^ {{(DATA_W-ADDR_W){1'b0}}, a};
    endfunction

    function automatic logic [ADDR_W-1:0] cont_addr(input int i);
        return ADDR_W'(16 * (i + 1));
    endfunction

    // Controller: counts command cycles, raises finished in the ctl_lat-th
    // cycle and holds it until the command drops.
    initial begin
        sdram_finished = 1'b0;
        sdram_readdata = '0;
        forever begin
            @(negedge clk);
            if (!i_rst || !(sdram_read || sdram_write)) begin
                sdram_finished = 1'b0;
                ctl_cnt        = 0;
            end else if (!sdram_finished) begin
                ctl_cnt++;
                if (ctl_cnt >= ctl_lat) begin
                    sdram_finished = 1'b1;
                    sdram_readdata = ctl_mode ? addr_data(sdram_addr) : ctl_rdata;
                end
            end
        end
    end

    // Completion monitor / scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_finished[i] === 1'b1) begin
                    n_done++;
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: finished pulse on master %0d, none expected", i);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.master != i || req_readdata[i] !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL sb_completion: got master %0d data %h, expected master %0d data %h",
                                     i, req_readdata[i], mon_e.master, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generic single-master transaction. Checks held address/data each BUSY
    // cycle, optionally perturbs the master's inputs mid-flight, and reports
    // how many cycles each command line was high.
    task automatic do_txn(input int m, input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int lat, input bit chg,
                          output int hi_rd, output int hi_wr);
        sb_t e;
        bit  seen;
        hi_rd   = 0;
        hi_wr   = 0;
        seen    = 1'b0;
        ctl_lat = lat;
        e.master = m;
        if (wr) begin
            e.data = model_rd[m];
        end else begin
            e.data      = ctl_rdata;
            model_rd[m] = ctl_rdata;
        end
        sb.push_back(e);
        @(negedge clk);
        req_addr[m]      = a;
        req_writedata[m] = d;
        req_read[m]      = rd;
        req_write[m]     = wr;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (sdram_read || sdram_write) begin
                hi_rd += int'(sdram_read);
                hi_wr += int'(sdram_write);
                n_checks++;
                if (sdram_addr !== a || (wr && sdram_writedata !== d)) begin
                    n_fail++;
                    $display("FAIL held_cmd: addr %h data %h, expected addr %h data %h",
                             sdram_addr, sdram_writedata, a, d);
                end
                if (chg) begin
                    req_addr[m]      = ~a;
                    req_writedata[m] = ~d;
                end
            end
            if (req_finished[m] === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (arb_grant !== GW'(m) || arb_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_state: grant %0d busy %b, expected grant %0d busy 1",
                             arb_grant, arb_busy, m);
                end
                req_read[m]  = 1'b0;
                req_write[m] = 1'b0;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL txn_timeout: master %0d never saw finished, expected a pulse", m);
            req_read[m]  = 1'b0;
            req_write[m] = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sdram_read !== 1'b0 || sdram_write !== 1'b0 || arb_busy !== 1'b0 || arb_grant !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd %b wr %b busy %b grant %0d, expected all 0",
                     sdram_read, sdram_write, arb_busy, arb_grant);
        end
        n_checks++;
        if (sdram_addr !== '0 || sdram_writedata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: addr %h wdata %h, expected 0 and 0", sdram_addr, sdram_writedata);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_checks++;
            if (req_readdata[i] !== '0 || req_finished[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_master: master %0d readdata %h finished %b, expected 0 and 0",
                         i, req_readdata[i], req_finished[i]);
            end
        end
        i_rst = 1'b1;
    endtask

    task automatic test_single_read();
        int hr, hw;
        ctl_mode  = 1'b0;
        ctl_rdata = 32'hDEAD_BEEF;
        do_txn(1, 1'b1, 1'b0, 23'h000100, '0, 4, 1'b0, hr, hw);
        n_checks++;
        if (hr != 4 || hw != 0) begin
            n_fail++;
            $display("FAIL read_cycles: rd %0d wr %0d cycles, expected 4 and 0", hr, hw);
        end
        @(negedge clk);
        n_checks++;
        if (arb_busy !== 1'b0 || req_readdata[0] !== model_rd[0] || req_readdata[2] !== model_rd[2]) begin
            n_fail++;
            $display("FAIL read_others: busy %b rd0 %h rd2 %h, expected 0 %h %h",
                     arb_busy, req_readdata[0], req_readdata[2], model_rd[0], model_rd[2]);
        end
    endtask

    task automatic test_single_write();
        int hr, hw;
        do_txn(0, 1'b0, 1'b1, 23'h7FFFFF, 32'h1234_5678, 3, 1'b0, hr, hw);
        n_checks++;
        if (hr != 0 || hw != 3) begin
            n_fail++;
            $display("FAIL write_cycles: rd %0d wr %0d cycles, expected 0 and 3", hr, hw);
        end
    endtask

    task automatic test_read_write_both();
        int hr, hw;
        do_txn(2, 1'b1, 1'b1, 23'h001234, 32'hCAFE_F00D, 2, 1'b0, hr, hw);
        n_checks++;
        if (hr != 0 || hw != 2) begin
            n_fail++;
            $display("FAIL rw_both: rd %0d wr %0d cycles, expected 0 and 2", hr, hw);
        end
    endtask

    task automatic test_mid_change();
        int hr, hw;
        ctl_rdata = 32'h0BAD_F00D;
        do_txn(0, 1'b1, 1'b0, 23'h000ABC, 32'h1111_2222, 3, 1'b1, hr, hw);
        n_checks++;
        if (hr != 3 || hw != 0) begin
            n_fail++;
            $display("FAIL mid_change_cycles: rd %0d wr %0d cycles, expected 3 and 0", hr, hw);
        end
    endtask

    task automatic test_contention();
        int  order [4];
        int  got;
        sb_t e;
`ifdef SDRAM_ARB_RR_EN
        order = '{0, 1, 2, 0};
`else
        order = '{0, 0, 0, 0};
`endif
        ctl_mode = 1'b1;
        ctl_lat  = 2;
        for (int k = 0; k < 4; k++) begin
            e.master = order[k];
            e.data   = addr_data(cont_addr(order[k]));
            model_rd[order[k]] = e.data;
            sb.push_back(e);
        end
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = cont_addr(i);
            req_read[i] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int c = 0; c < 30 && got < 0; c++) begin
                @(negedge clk);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_finished[i] === 1'b1) got = i;
                end
            end
            n_checks++;
            if (got != order[k]) begin
                n_fail++;
                $display("FAIL grant_order: slot %0d granted %0d, expected %0d", k, got, order[k]);
            end
            if (got >= 0) req_read[got] = 1'b0;
            @(negedge clk);
            n_checks++;
            if (arb_busy !== 1'b0 || sdram_read !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_gap: busy %b rd %b in gap cycle, expected 0 and 0", arb_busy, sdram_read);
            end
            if (k < 3) begin
                if (got >= 0) req_read[got] = 1'b1;
                @(negedge clk);
                n_checks++;
                if (sdram_read !== 1'b1) begin
                    n_fail++;
                    $display("FAIL back_to_back: rd %b after one idle cycle, expected 1", sdram_read);
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) req_read[i] = 1'b0;
            end
        end
        ctl_mode = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_busy();
        int hr, hw;
        int n0;
        ctl_lat   = 10;
        ctl_rdata = 32'h5555_AAAA;
        @(negedge clk);
        req_addr[1] = 23'h000200;
        req_read[1] = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sdram_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy_pre: rd %b before reset, expected 1", sdram_read);
        end
        i_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sdram_read !== 1'b0 || arb_busy !== 1'b0 || req_finished[1] !== 1'b0 || req_readdata[1] !== '0) begin
            n_fail++;
            $display("FAIL rst_busy: rd %b busy %b fin %b rd1 %h, expected 0 0 0 0",
                     sdram_read, arb_busy, req_finished[1], req_readdata[1]);
        end
        i_rst       = 1'b1;
        req_read[1] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) model_rd[i] = '0;
        n0 = n_done;
        repeat (12) @(negedge clk);
        n_checks++;
        if (n_done != n0) begin
            n_fail++;
            $display("FAIL rst_no_finish: %0d pulses after reset, expected 0", n_done - n0);
        end
        ctl_rdata = 32'h0F0F_1234;
        do_txn(2, 1'b1, 1'b0, 23'h000300, '0, 2, 1'b0, hr, hw);
        n_checks++;
        if (hr != 2 || hw != 0) begin
            n_fail++;
            $display("FAIL rst_recover: rd %0d wr %0d cycles, expected 2 and 0", hr, hw);
        end
    endtask

    initial begin
        i_rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_read[i]      = 1'b0;
            req_write[i]     = 1'b0;
            req_addr[i]      = '0;
            req_writedata[i] = '0;
            model_rd[i]      = '0;
        end
        test_reset();
        test_single_read();
        test_single_write();
        test_read_write_both();
        test_mid_change();
        test_contention();
        test_reset_busy();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d completions outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
